// File: rtl/ascon_pack.sv
// Shared types and sizes for the ASCON plaintext release path.
// Optional build macro: ASCON_VERIFY_ZEROIZE_EN (see ascon_verify_release.sv).
package ascon_pack;

    localparam int ASCON_MAX_WORDS = 4;
    localparam int ASCON_TAG_W     = 128;
    localparam int ASCON_WORD_W    = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_WAIT_REF = 3'd2,
        ST_CHECK    = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_FAIL     = 3'd5
    } verify_state_t;

endpackage

// File: rtl/ascon_word_buffer.sv
// Plaintext holding buffer: DEPTH x 64 register file, write/read pointers,
// word count and a sticky overflow flag. Pointers never wrap; clr_i restarts
// a message. With ASCON_VERIFY_ZEROIZE_EN defined, wipe_i also zeroes every
// entry in one cycle.
module ascon_word_buffer
    import ascon_pack::*;
#(
    parameter  int DEPTH = ASCON_MAX_WORDS,
    localparam int PW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic                    wipe_i,
    input  logic                    wr_en_i,
    input  logic [ASCON_WORD_W-1:0] wr_data_i,
    input  logic                    rd_adv_i,
    output logic [PW-1:0]           count_o,
    output logic [PW-1:0]           rd_ptr_o,
    output logic [ASCON_WORD_W-1:0] rd_data_o,
    output logic                    ovf_o
);

    logic [ASCON_WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           count;
    logic                    ovf;

`ifndef ASCON_VERIFY_ZEROIZE_EN
    logic unused_wipe;
    assign unused_wipe = wipe_i;
`endif

    // Store words, advance pointers, and flag writes that find the buffer full.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (clr_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                ovf    <= 1'b0;
            end else begin
                if (wr_en_i) begin
                    if (count == PW'(DEPTH)) begin
                        ovf <= 1'b1;
                    end else begin
                        mem[wr_ptr[AW-1:0]] <= wr_data_i;
                        wr_ptr              <= wr_ptr + PW'(1);
                        count               <= count + PW'(1);
                    end
                end
                if (rd_adv_i) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
`ifdef ASCON_VERIFY_ZEROIZE_EN
            if (wipe_i) begin
                mem <= '{default: '0};
            end
`endif
        end
    end

    assign count_o   = count;
    assign rd_ptr_o  = rd_ptr;
    assign rd_data_o = mem[rd_ptr[AW-1:0]];
    assign ovf_o     = ovf;

endmodule

// File: rtl/ascon_verify_release.sv
// Plaintext release gate behind the ASCON decrypt core. Buffers decrypted
// words, latches the computed and reference tags, and releases the words only
// when the tags match; otherwise the message is dropped and auth_fail_o set.
// Optional build macro: ASCON_VERIFY_ZEROIZE_EN -- wipes buffer and computed
// tag on failure/abort and forces data_o to 0 whenever data_valid_o is low.
//
// Output stream: a word transfers on a cycle where data_valid_o and
// data_ready_i are both high; while data_valid_o is high and data_ready_i is
// low, data_o and data_valid_o hold their values.
module ascon_verify_release
    import ascon_pack::*;
#(
    parameter  int DEPTH = ASCON_MAX_WORDS,
    localparam int PW    = $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ASCON_WORD_W-1:0] data_i,
    input  logic                    data_valid_i,
    input  logic                    end_i,
    input  logic [ASCON_TAG_W-1:0]  tag_i,
    input  logic [ASCON_TAG_W-1:0]  tag_ref_i,
    input  logic                    tag_ref_valid_i,
    output logic [ASCON_WORD_W-1:0] data_o,
    output logic                    data_valid_o,
    input  logic                    data_ready_i,
    output logic                    auth_ok_o,
    output logic                    auth_fail_o,
    output logic                    done_o,
    output logic                    busy_o,
    output verify_state_t           state_o,
    output logic [PW-1:0]           count_o
);

    verify_state_t            state;
    logic                     valid_q;
    logic                     end_q;
    logic [ASCON_TAG_W-1:0]   tag_q;
    logic [ASCON_TAG_W-1:0]   ref_q;
    logic                     ref_ok;
    logic                     auth_ok;
    logic                     auth_fail;

    logic [PW-1:0]            count;
    logic [PW-1:0]            rd_ptr;
    logic [ASCON_WORD_W-1:0]  rd_data;
    logic                     ovf;

    logic dv_edge, end_edge, abort, wr_en, tag_eq, pass, fail_enter, wipe, rd_adv;

    // Edge detection, write/read strobes and the full-width tag compare.
    always_comb begin
        dv_edge      = data_valid_i & ~valid_q;
        end_edge     = end_i & ~end_q;
        abort        = start_i & (state != ST_IDLE);
        wr_en        = (state == ST_COLLECT) & dv_edge & ~start_i;
        tag_eq       = (tag_q == ref_q);
        pass         = tag_eq & ~ovf;
        fail_enter   = (state == ST_CHECK) & ~pass & ~start_i;
        wipe         = abort | fail_enter;
        data_valid_o = (state == ST_RELEASE) & (rd_ptr != count);
        rd_adv       = data_valid_o & data_ready_i & ~start_i;
        done_o       = (state == ST_FAIL) | ((state == ST_RELEASE) & (rd_ptr == count));
    end

    ascon_word_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (start_i),
        .wipe_i    (wipe),
        .wr_en_i   (wr_en),
        .wr_data_i (data_i),
        .rd_adv_i  (rd_adv),
        .count_o   (count),
        .rd_ptr_o  (rd_ptr),
        .rd_data_o (rd_data),
        .ovf_o     (ovf)
    );

    // Message sequencing: collect, wait for reference, compare, release or fail.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            valid_q   <= 1'b0;
            end_q     <= 1'b0;
            tag_q     <= '0;
            ref_q     <= '0;
            ref_ok    <= 1'b0;
            auth_ok   <= 1'b0;
            auth_fail <= 1'b0;
        end else begin
            valid_q <= data_valid_i;
            end_q   <= end_i;
            if (start_i) begin
                state     <= ST_COLLECT;
                tag_q     <= '0;
                ref_q     <= '0;
                ref_ok    <= 1'b0;
                auth_ok   <= 1'b0;
                auth_fail <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_COLLECT: begin
                        if (tag_ref_valid_i) begin
                            ref_q  <= tag_ref_i;
                            ref_ok <= 1'b1;
                        end
                        if (end_edge) begin
                            tag_q <= tag_i;
                            state <= (ref_ok | tag_ref_valid_i) ? ST_CHECK : ST_WAIT_REF;
                        end
                    end
                    ST_WAIT_REF: begin
                        if (tag_ref_valid_i) begin
                            ref_q  <= tag_ref_i;
                            ref_ok <= 1'b1;
                            state  <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (pass) begin
                            auth_ok <= 1'b1;
                            state   <= ST_RELEASE;
                        end else begin
                            auth_fail <= 1'b1;
                            state     <= ST_FAIL;
`ifdef ASCON_VERIFY_ZEROIZE_EN
                            tag_q     <= '0;
`endif
                        end
                    end
                    ST_RELEASE: begin
                        if (rd_ptr == count) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_FAIL: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef ASCON_VERIFY_ZEROIZE_EN
    assign data_o = data_valid_o ? rd_data : '0;
`else
    assign data_o = rd_data;
`endif

    assign auth_ok_o   = auth_ok;
    assign auth_fail_o = auth_fail;
    assign busy_o      = (state != ST_IDLE);
    assign state_o     = state;
    assign count_o     = count;

endmodule

// File: tb/tb_ascon_verify_release.sv
// Directed bench for ascon_verify_release: match, mismatch, backpressure,
// late reference, overflow, abort and asynchronous reset.
module tb_ascon_verify_release;
    import ascon_pack::*;

    localparam logic [127:0] TAG_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [63:0]  W1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0]  W2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0]  W3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0]  WA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0]  WB = 64'hBBBB_BBBB_BBBB_BBBB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [63:0]   data_i = '0;
    logic          data_valid_i = 1'b0;
    logic          end_i = 1'b0;
    logic [127:0]  tag_i = '0;
    logic [127:0]  tag_ref_i = '0;
    logic          tag_ref_valid_i = 1'b0;
    logic          data_ready_i = 1'b1;
    logic [63:0]   data_o;
    logic          data_valid_o;
    logic          auth_ok_o;
    logic          auth_fail_o;
    logic          done_o;
    logic          busy_o;
    verify_state_t state_o;
    logic [2:0]    count_o;

    ascon_verify_release dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .data_i          (data_i),
        .data_valid_i    (data_valid_i),
        .end_i           (end_i),
        .tag_i           (tag_i),
        .tag_ref_i       (tag_ref_i),
        .tag_ref_valid_i (tag_ref_valid_i),
        .data_o          (data_o),
        .data_valid_o    (data_valid_o),
        .data_ready_i    (data_ready_i),
        .auth_ok_o       (auth_ok_o),
        .auth_fail_o     (auth_fail_o),
        .done_o          (done_o),
        .busy_o          (busy_o),
        .state_o         (state_o),
        .count_o         (count_o)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int done_cnt = 0;

    // Record every transferred word and every done pulse mid-cycle.
    always @(negedge clk) begin
        if (rst_i && data_valid_o && data_ready_i) got_q.push_back(data_o);
        if (rst_i && done_o) done_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Compare words released since got_base against exp_q, then empty exp_q.
    task automatic chk_release(input string tag, input int got_base);
        chk({tag, "_n"}, 128'(got_q.size() - got_base), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_base + i < got_q.size())
                chk($sformatf("%s_w%0d", tag, i), 128'(got_q[got_base + i]), 128'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_msg();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w, input int hold);
        data_i       = w;
        data_valid_i = 1'b1;
        repeat (hold) tick();
        data_valid_i = 1'b0;
        tick();
    endtask

    // One-cycle end_i pulse, optionally with the reference tag alongside.
    task automatic end_msg(input logic [127:0] t, input logic [127:0] r, input logic rv);
        tag_i           = t;
        tag_ref_i       = r;
        tag_ref_valid_i = rv;
        end_i           = 1'b1;
        tick();
        end_i           = 1'b0;
        tag_ref_valid_i = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int gb;
        int db;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state_o, ST_IDLE);
        chk("rst_data", data_o, 0);
        chk("rst_valid", data_valid_o, 0);
        chk("rst_ok", auth_ok_o, 0);
        chk("rst_fail", auth_fail_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_i = 1'b1;
        tick();

        // 1: matching tag, three words each held 3 cycles
        gb = got_q.size(); db = done_cnt;
        start_msg();
        chk("m_start_state", state_o, ST_COLLECT);
        chk("m_start_busy", busy_o, 1);
        send_word(W1, 3);
        chk("m_count1", count_o, 1);
        send_word(W2, 3);
        send_word(W3, 3);
        chk("m_count3", count_o, 3);
        end_msg(TAG_A, TAG_A, 1'b1);
        chk("m_check", state_o, ST_CHECK);
        tick();
        chk("m_release", state_o, ST_RELEASE);
        chk("m_valid", data_valid_o, 1);
        chk("m_first", data_o, W1);
        chk("m_ok", auth_ok_o, 1);
        chk("m_nodone", done_o, 0);
        tick(); tick(); tick();
        chk("m_done", done_o, 1);
        chk("m_valid_end", data_valid_o, 0);
        tick();
        chk("m_idle", state_o, ST_IDLE);
        chk("m_ok_held", auth_ok_o, 1);
        exp_q.push_back(W1); exp_q.push_back(W2); exp_q.push_back(W3);
        chk_release("m_rel", gb);
        chk("m_done_cnt", done_cnt - db, 1);

        // 2: mismatch in bit 0
        gb = got_q.size(); db = done_cnt;
        start_msg();
        chk("x_ok_clr", auth_ok_o, 0);
        send_word(W1, 3);
        send_word(W2, 3);
        send_word(W3, 3);
        end_msg(TAG_A, TAG_A ^ 128'h1, 1'b1);
        chk("x_check", state_o, ST_CHECK);
        tick();
        chk("x_fail_state", state_o, ST_FAIL);
        chk("x_fail", auth_fail_o, 1);
        chk("x_done", done_o, 1);
        chk("x_valid", data_valid_o, 0);
        chk("x_ok", auth_ok_o, 0);
        tick();
        chk("x_idle", state_o, ST_IDLE);
        chk("x_fail_held", auth_fail_o, 1);
`ifdef ASCON_VERIFY_ZEROIZE_EN
        chk("x_data_wiped", data_o, 0);
`else
        chk("x_data_stale", data_o, W1);
`endif
        chk_release("x_rel", gb);
        chk("x_done_cnt", done_cnt - db, 1);

        // 3: backpressure during word 2
        gb = got_q.size();
        start_msg();
        chk("b_fail_clr", auth_fail_o, 0);
        send_word(W1, 3);
        send_word(W2, 3);
        send_word(W3, 3);
        end_msg(TAG_A, TAG_A, 1'b1);
        tick();
        chk("b_first", data_o, W1);
        tick();
        data_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("b_hold_d%0d", i), data_o, W2);
            chk($sformatf("b_hold_v%0d", i), data_valid_o, 1);
            tick();
        end
        data_ready_i = 1'b1;
        chk("b_hold_last", data_o, W2);
        tick();
        chk("b_third", data_o, W3);
        tick();
        chk("b_done", done_o, 1);
        tick();
        exp_q.push_back(W1); exp_q.push_back(W2); exp_q.push_back(W3);
        chk_release("b_rel", gb);

        // 4: late reference, stray word in WAIT_REF ignored
        gb = got_q.size();
        start_msg();
        send_word(WA, 2);
        send_word(WB, 2);
        end_msg(TAG_A, '0, 1'b0);
        chk("l_wait", state_o, ST_WAIT_REF);
        data_i = W3; data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
        tick(); tick();
        chk("l_still_wait", state_o, ST_WAIT_REF);
        tag_ref_i = TAG_A; tag_ref_valid_i = 1'b1;
        tick();
        tag_ref_valid_i = 1'b0;
        chk("l_check", state_o, ST_CHECK);
        chk("l_count", count_o, 2);
        tick();
        chk("l_release", state_o, ST_RELEASE);
        chk("l_ok", auth_ok_o, 1);
        tick(); tick();
        chk("l_done", done_o, 1);
        tick();
        exp_q.push_back(WA); exp_q.push_back(WB);
        chk_release("l_rel", gb);

        // 5: overflow, five edges into four entries
        gb = got_q.size();
        start_msg();
        for (int i = 0; i < 5; i++) send_word(64'(i + 1), 1);
        chk("o_count", count_o, 4);
        end_msg(TAG_A, TAG_A, 1'b1);
        tick();
        chk("o_fail_state", state_o, ST_FAIL);
        chk("o_fail", auth_fail_o, 1);
        chk("o_ok", auth_ok_o, 0);
        chk("o_valid", data_valid_o, 0);
        tick();
        chk_release("o_rel", gb);

        // 6: abort mid-release, then reset mid-collect
        start_msg();
        send_word(W1, 1);
        send_word(W2, 1);
        end_msg(TAG_A, TAG_A, 1'b1);
        tick();
        chk("a_release", state_o, ST_RELEASE);
        data_ready_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        data_ready_i = 1'b1;
        chk("a_state", state_o, ST_COLLECT);
        chk("a_count", count_o, 0);
        chk("a_ok", auth_ok_o, 0);
        chk("a_valid", data_valid_o, 0);
        send_word(W3, 2);
        chk("a_count1", count_o, 1);
        #2 rst_i = 1'b0;
        #1;
        chk("r_state", state_o, ST_IDLE);
        chk("r_busy", busy_o, 0);
        chk("r_count", count_o, 0);
        chk("r_data", data_o, 0);
        chk("r_valid", data_valid_o, 0);
        chk("r_done", done_o, 0);
        tick();
        rst_i = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ascon_verify_release.md
# ascon_verify_release

Plaintext release gate downstream of `ASCON_Top_decrypt`. It buffers every decrypted 64-bit word the decrypt core produces and captures the computed tag at end of message. It then compares that tag with the reference tag delivered with the ciphertext. Plaintext reaches the consumer over a valid/ready stream only when the tags match; on mismatch the buffer is discarded and a failure is flagged.

## Interface
Parameters:
- `DEPTH`, default `ASCON_MAX_WORDS` (4): maximum plaintext words per message.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  begin a new message; clears the buffer, pointers, latched tags and flags.
- `data_i`  in  64  plaintext word from the decrypt core (`data_o`).
- `data_valid_i`  in  1  plaintext valid from the decrypt core; may stay high several cycles per word.
- `end_i`  in  1  end of decryption from the core (`end_o`); `tag_i` is valid while it is high.
- `tag_i`  in  128  computed tag from the core.
- `tag_ref_i`  in  128  expected (received) tag.
- `tag_ref_valid_i`  in  1  `tag_ref_i` valid; sampled in COLLECT and WAIT_REF.
- `data_o`  out  64  released plaintext word.
- `data_valid_o`  out  1  `data_o` valid.
- `data_ready_i`  in  1  consumer accepts `data_o`.
- `auth_ok_o`  out  1  tags matched; held until next `start_i` or reset.
- `auth_fail_o`  out  1  tag mismatch or overflow; held until next `start_i` or reset.
- `done_o`  out  1  one-cycle pulse when a message completes (release finished or fail).
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, COLLECT, WAIT_REF, CHECK, RELEASE, FAIL.
- IDLE: `start_i` -> COLLECT. `wr_ptr`, `rd_ptr`, `count`, `ref_ok` and the flags are cleared.
- Word capture happens only on the rising edge of `data_valid_i`, i.e. `data_valid_i & ~valid_q`, where `valid_q` is `data_valid_i` registered.
  - On that edge `data_i` is written to `buf[wr_ptr]` and `count` increments.
  - A valid level held for N cycles is one word.
- Overflow: an edge arriving when `count == DEPTH` sets `ovf`. The word is dropped and the message is forced to fail.
- `tag_ref_valid_i` in COLLECT or WAIT_REF latches `tag_ref_i` and sets `ref_ok`. Later assertions in the same message overwrite the latch.
- End of message: the `end_i` rising edge in COLLECT latches `tag_i`.
  - If `ref_ok`, or `tag_ref_valid_i` is high that same cycle, -> CHECK; otherwise -> WAIT_REF.
  - A `data_valid_i` edge in the same cycle as the `end_i` edge is captured first, so it belongs to this message.
- WAIT_REF: `tag_ref_valid_i` -> CHECK. Plaintext edges arriving in WAIT_REF are ignored.
- CHECK: one cycle doing a full 128-bit equality with no early exit.
  - Equal and `!ovf` -> RELEASE, setting `auth_ok_o`.
  - Otherwise -> FAIL.
- RELEASE:
  - `data_valid_o = (rd_ptr != count)` and `data_o = buf[rd_ptr]`.
  - `data_valid_o & data_ready_i` advances `rd_ptr`.
  - Once `rd_ptr == count`, `done_o` is pulsed and the state -> IDLE.
  - With `count == 0`, the state goes straight to IDLE with the `done_o` pulse and `data_valid_o` never rises.
  - `data_o` and `data_valid_o` are stable while `data_valid_o & !data_ready_i`.
- FAIL: set `auth_fail_o`, pulse `done_o`, -> IDLE. No word is ever presented.
- `start_i` in any non-IDLE state aborts the current message. The state re-enters COLLECT with everything cleared; pending release words are discarded.
- Simultaneous `start_i` and `end_i`: `start_i` wins.

## Timing
- Reset values: state IDLE, `data_o = 0`, `data_valid_o = 0`, `auth_ok_o = 0`, `auth_fail_o = 0`, `done_o = 0`, `busy_o = 0`, all pointers 0, `valid_q = 0`, buffer contents 0.
- `start_i` at cycle t: COLLECT and `busy_o = 1` at t+1.
- Word captured at the `data_valid_i` edge cycle; `count` is updated at t+1.
- `end_i` edge at t with the reference tag present: CHECK at t+1; RELEASE (with `data_valid_o` high) or FAIL at t+2.
- With an always-ready consumer, release takes one word per cycle, so `done_o` occurs at t+2+count. FAIL pulses `done_o` at t+2.
- Pointers are `$clog2(DEPTH+1)` bits wide and never wrap; each message starts at 0.

## Configuration
- `ASCON_VERIFY_ZEROIZE_EN` defined:
  - Entering FAIL, or an abort via `start_i`, zeroes all `DEPTH` buffer entries and the latched `tag_i` in that single cycle.
  - `data_o` is forced to 0 whenever `data_valid_o = 0`.
- Not defined: only pointers and flags are cleared. Stale buffer contents remain, and `data_o` shows `buf[rd_ptr]` regardless of valid.

## Structure
- `ascon_pack` gains:
  - `typedef enum logic [2:0] {...} verify_state_t`;
  - `localparam int ASCON_MAX_WORDS = 4`;
  - `localparam int ASCON_TAG_W = 128`.
- Sub-module `ascon_word_buffer`: `DEPTH`×64 register file with write and read pointers, `count`, an overflow flag and a clear input (zeroizing under the macro).
- The FSM, edge detectors and tag comparator live in `ascon_verify_release`.

## Test plan
- Matching tag, 3 words:
  - Stimulus: `start_i`, then words 64'h1111…, 64'h2222…, 64'h3333…, each with `data_valid_i` held 3 cycles; then `end_i` with `tag_i = tag_ref_i = 128'h0123456789ABCDEF_FEDCBA9876543210`.
  - Response: CHECK, then the three words are released in order, `auth_ok_o = 1`, one `done_o` pulse.
- Mismatch:
  - Stimulus: same words, with `tag_ref_i` differing in bit 0.
  - Response: `auth_fail_o = 1`, `data_valid_o` never rises, `done_o` pulse. With `ASCON_VERIFY_ZEROIZE_EN`, the buffer reads all zeros.
- Backpressure:
  - Stimulus: matching tags, with `data_ready_i` low for 5 cycles during word 2.
  - Response: `data_o` holds 64'h2222… stable, and there are no duplicate or lost words.
- Late reference:
  - Stimulus: `end_i` edge arrives with `tag_ref_valid_i` low; the reference arrives 4 cycles later.
  - Response: WAIT_REF, then CHECK one cycle after the reference, then RELEASE.
- Overflow:
  - Stimulus: 5 valid edges with `DEPTH = 4` and matching tags.
  - Response: `auth_fail_o = 1`, no words released.
- Abort and reset:
  - Stimulus: `start_i` asserted mid-RELEASE.
  - Response: COLLECT next cycle with `count = 0`, `auth_ok_o = 0`.
  - Stimulus: `rst_i` low mid-COLLECT.
  - Response: all outputs at reset values immediately.
